aes_encrypt_iter: RTL and testbench
===================================

Name: aes_encrypt_iter

Overview:
Iterative AES-128/192/256 encryption core. It computes one round per clock from a precomputed, expanded key schedule and is the encrypt-side counterpart of the combinational decrypt datapath. It uses the same Words layout as the decrypt datapath, so one key-expansion result drives both directions. Valid/ready handshakes on input and output let it sit behind a stream source and in front of a ciphertext sink.

Parameters:
KeySize, 128, key length in bits; legal values are 128, 192 and 256. Any other value is an elaboration error.
Nr (localparam), KeySize/32+6, number of rounds: 10, 12 or 14.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
PlainText  input  128  block to encrypt; byte 0 = [127:120], column-major per FIPS-197
in_valid  input  1  PlainText is valid
in_ready  output  1  core can accept a block
Words  input  128*(Nr+1)  expanded key schedule
CipherText  output  128  encrypted block, registered
out_valid  output  1  CipherText is valid
out_ready  input  1  sink accepts CipherText
busy  output  1  a block is in flight (state ROUND or DONE)

Behaviour:
- Round key k, for k = 0..Nr:
  - {Words[128k+31-:32], Words[128k+63-:32], Words[128k+95-:32], Words[128k+127-:32]}
  - The lowest word of each 128-bit slice becomes the most significant word of the round key.
- Words is not registered. The source holds it stable from the input handshake until the output handshake.
- FSM states: IDLE, ROUND, DONE.
  - Round counter rnd is 4 bits; the state register st is 128 bits.
- IDLE:
  - in_ready=1.
  - On in_valid: st <= PlainText ^ key0, rnd <= 1, go to ROUND.
- ROUND, rnd < Nr:
  - st <= MixColumns(ShiftRows(SubBytes(st))) ^ key[rnd].
  - rnd <= rnd+1.
- ROUND, rnd == Nr:
  - CipherText <= ShiftRows(SubBytes(st)) ^ key[Nr]; no MixColumns.
  - out_valid <= 1, go to DONE.
- DONE:
  - CipherText and out_valid are held until out_ready=1.
  - On that edge: out_valid <= 0, go to IDLE. in_ready rises the following cycle.
- in_ready = (state==IDLE) and is driven combinationally from the state register. in_valid/PlainText are ignored outside IDLE.
- Latency: a handshake at edge T gives out_valid=1 after edge T+Nr, i.e. 10, 12 or 14 cycles.
  - Minimum block period is Nr+2 cycles with out_ready held high.
- out_ready while out_valid=0 has no effect. out_valid never drops without an out_ready handshake.
- CipherText keeps its last value after the handshake until the next block completes.
- Reset (async assert, any state including mid-round):
  - state=IDLE, rnd=0, st=0, CipherText=0, out_valid=0, busy=0.
  - in_ready=1 once rst is deasserted.
  - A block in flight is dropped without any output.
- Arithmetic: GF(2^8) with polynomial 0x11B. xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
- X or Z on Words or PlainText is never sampled outside the capturing or round edges.

Decomposition:
- Shared package/include aes_pkg:
  - forward S-box table function.
  - xtime.
  - Nr function of KeySize.
  - byte-index helper for column-major state.
- One combinational sub-module, aes_enc_round:
  - inputs: state_in[127:0], round_key[127:0], final_round.
  - output: state_out. MixColumns is bypassed when final_round=1.
  - contains 16 S-box instances, ShiftRows, MixColumns and AddRoundKey.
- Top level holds the FSM, counter, registers and key-slice mux.

Test Plan:
1. KeySize=128, PT=00112233445566778899aabbccddeeff, key=000102..0f expanded -> CipherText=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 10 cycles after the handshake.
2. KeySize=128, PT=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32. Also check the intermediate st after round 1 against FIPS-197 Appendix B.
3. KeySize=192, key=00..17, PT as in 1 -> dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles. KeySize=256, key=00..1f -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
4. Backpressure: out_ready=0 for 20 cycles after out_valid. CipherText, out_valid and busy stay stable and in_ready=0 throughout; a PlainText offered during this time is not accepted. After out_ready=1, in_ready=1 on the next cycle.
5. Reset mid-operation: assert rst at round 5 of the first block, asynchronously between edges. Outputs are 0 immediately and in_ready=1 after deassert. The next block (vector 2) gives the correct result.
6. Back-to-back: 50 random PT/key pairs at KeySize=128 with out_ready=1 constantly, each checked against a reference model. Block period must be exactly 12 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers: forward S-box, GF(2^8) xtime, round count and
// column-major byte addressing of the 128-bit state.
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } enc_state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] lsb;
    lsb = {~b, 3'b000};
    return SBOX_TBL[lsb +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int unsigned nr_of(input int unsigned key_size);
    return key_size / 32 + 6;
  endfunction

  // LSB position of byte (row, col); byte 0 sits at [127:120].
  function automatic int unsigned byte_lsb(input int unsigned row, input int unsigned col);
    return 120 - 8 * (4 * col + row);
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows,
// MixColumns (skipped on the final round) and AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [7:0] sub [4][4];
  logic [7:0] shf [4][4];
  logic [7:0] mix [4][4];

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sub[r][c] = sbox(state_in[byte_lsb(r, c) +: 8]);
      // Row r rotates left by r columns.
      assign shf[r][c] = sub[r][(c + r) % 4];
      assign state_out[byte_lsb(r, c) +: 8] =
        (final_round ? shf[r][c] : mix[r][c]) ^ round_key[byte_lsb(r, c) +: 8];
    end

    assign mix[0][c] = xtime(shf[0][c]) ^ xtime(shf[1][c]) ^ shf[1][c] ^ shf[2][c] ^ shf[3][c];
    assign mix[1][c] = shf[0][c] ^ xtime(shf[1][c]) ^ xtime(shf[2][c]) ^ shf[2][c] ^ shf[3][c];
    assign mix[2][c] = shf[0][c] ^ shf[1][c] ^ xtime(shf[2][c]) ^ xtime(shf[3][c]) ^ shf[3][c];
    assign mix[3][c] = xtime(shf[0][c]) ^ shf[0][c] ^ shf[1][c] ^ shf[2][c] ^ xtime(shf[3][c]);
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor, one round per clock, driven by a
// pre-expanded key schedule with valid/ready on both sides.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter  int unsigned KeySize = 128,
  localparam int unsigned Nr      = nr_of(KeySize)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [127:0]          PlainText,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [128*(Nr+1)-1:0] Words,
  output logic [127:0]          CipherText,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  if (!(KeySize == 128 || KeySize == 192 || KeySize == 256)) begin : g_bad_key_size
    $error("aes_encrypt_iter: KeySize must be 128, 192 or 256");
  end

  enc_state_e         state, state_d;
  logic [3:0]         rnd, rnd_d;
  logic [BLOCK_W-1:0] st, st_d;
  logic [BLOCK_W-1:0] ct_d;
  logic               out_valid_d, busy_d;

  logic [BLOCK_W-1:0] rk [Nr+1];
  logic [BLOCK_W-1:0] round_key;
  logic [BLOCK_W-1:0] round_out;
  logic               last_round;

  // Lowest word of each slice is the most significant word of the round key.
  for (genvar k = 0; k <= Nr; k++) begin : g_rk
    assign rk[k] = {Words[128*k+31 -: 32], Words[128*k+63 -: 32],
                    Words[128*k+95 -: 32], Words[128*k+127 -: 32]};
  end

  assign round_key  = rk[rnd];
  assign last_round = (rnd == 4'(Nr));
  assign in_ready   = (state == ST_IDLE);

  aes_enc_round u_round (
    .state_in    (st),
    .round_key   (round_key),
    .final_round (last_round),
    .state_out   (round_out)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state;
    rnd_d       = rnd;
    st_d        = st;
    ct_d        = CipherText;
    out_valid_d = out_valid;
    busy_d      = busy;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          st_d    = PlainText ^ rk[0];
          rnd_d   = 4'd1;
          busy_d  = 1'b1;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (last_round) begin
          ct_d        = round_out;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          st_d  = round_out;
          rnd_d = rnd + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rnd        <= 4'd0;
      st         <= '0;
      CipherText <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      rnd        <= rnd_d;
      st         <= st_d;
      CipherText <= ct_d;
      out_valid  <= out_valid_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: known vectors at all key sizes,
// backpressure, mid-block reset and randomized back-to-back blocks vs a model.
module tb_aes_encrypt_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] pt = '0;
  logic iv128 = 0, iv192 = 0, iv256 = 0;
  logic or128 = 0, or192 = 0, or256 = 0;
  logic ir128, ir192, ir256, ov128, ov192, ov256, bz128, bz192, bz256;
  logic [127:0] ct128, ct192, ct256;
  logic [1407:0] w128 = '0;
  logic [1663:0] w192 = '0;
  logic [1919:0] w256 = '0;

  int n_pass = 0;
  int n_total = 0;
  logic [127:0] r1_obs;

  logic [7:0]  sbox_m [256];
  logic [31:0] kw [60];

  always #5 clk = ~clk;

  aes_encrypt_iter #(.KeySize(128)) dut128 (
    .clk(clk), .rst(rst), .PlainText(pt), .in_valid(iv128), .in_ready(ir128),
    .Words(w128), .CipherText(ct128), .out_valid(ov128), .out_ready(or128), .busy(bz128));
  aes_encrypt_iter #(.KeySize(192)) dut192 (
    .clk(clk), .rst(rst), .PlainText(pt), .in_valid(iv192), .in_ready(ir192),
    .Words(w192), .CipherText(ct192), .out_valid(ov192), .out_ready(or192), .busy(bz192));
  aes_encrypt_iter #(.KeySize(256)) dut256 (
    .clk(clk), .rst(rst), .PlainText(pt), .in_valid(iv256), .in_ready(ir256),
    .Words(w256), .CipherText(ct256), .out_valid(ov256), .out_ready(or256), .busy(bz256));

  // ---------------- reference model (FIPS-197 arithmetic) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from multiplicative inverse plus affine map.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] tmp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) kw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      tmp = kw[i-1];
      if (i % nk == 0) begin
        tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      kw[i] = kw[i-nk] ^ tmp;
    end
  endtask

  function automatic logic [7:0] rkb(input int k, input int i);
    logic [31:0] w;
    w = kw[4*k + i/4];
    return w[31-8*(i%4) -: 8];
  endfunction

  task automatic model_enc(input logic [127:0] p, input int nr, output logic [127:0] c);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] coef [4];
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rkb(0, i);
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
      for (int r = 0; r < 4; r++)
        for (int cc = 0; cc < 4; cc++) t[r+4*cc] = s[r+4*((cc+r)%4)];
      for (int cc = 0; cc < 4; cc++)
        for (int r = 0; r < 4; r++) begin
          if (rd < nr) begin
            s[r+4*cc] = '0;
            for (int j = 0; j < 4; j++) s[r+4*cc] = s[r+4*cc] ^ gmul(t[j+4*cc], coef[(j-r+4)%4]);
          end else begin
            s[r+4*cc] = t[r+4*cc];
          end
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkb(rd, i);
    end
    for (int i = 0; i < 16; i++) c[127-8*i -: 8] = s[i];
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_key(input logic [255:0] key, input int nk);
    logic [1919:0] wv;
    expand(key, nk);
    wv = '0;
    for (int j = 0; j < 4 * (nk + 7); j++) wv[32*j +: 32] = kw[j];
    case (nk)
      4:       w128 = wv[1407:0];
      6:       w192 = wv[1663:0];
      default: w256 = wv;
    endcase
  endtask

  function automatic logic ir_of(input int ks);
    return (ks == 128) ? ir128 : (ks == 192) ? ir192 : ir256;
  endfunction
  function automatic logic ov_of(input int ks);
    return (ks == 128) ? ov128 : (ks == 192) ? ov192 : ov256;
  endfunction
  function automatic logic [127:0] ct_of(input int ks);
    return (ks == 128) ? ct128 : (ks == 192) ? ct192 : ct256;
  endfunction
  task automatic set_iv(input int ks, input logic v);
    case (ks)
      128:     iv128 = v;
      192:     iv192 = v;
      default: iv256 = v;
    endcase
  endtask

  // Handshake one block, then count edges until out_valid (bounded).
  task automatic do_block(input int ks, input logic [127:0] p,
                          output logic [127:0] c, output int lat);
    pt = p;
    set_iv(ks, 1'b1);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ir_of(ks)) break;
    end
    @(posedge clk); #1;
    set_iv(ks, 1'b0);
    lat = 0;
    while (!ov_of(ks) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) r1_obs = dut128.st;
    end
    c = ct_of(ks);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (ir128 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", ir128); else n_pass++;
    n_total++; if (ov128 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", ov128); else n_pass++;
    n_total++; if (bz128 !== 1'b0) $display("FAIL reset_busy got %b want 0", bz128); else n_pass++;
    n_total++; if (ct128 !== 128'h0) $display("FAIL reset_ct got %h want 0", ct128); else n_pass++;
  endtask

  task automatic test_vec128();
    logic [127:0] c;
    int lat;
    or128 = 1'b1;
    set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    do_block(128, 128'h00112233445566778899aabbccddeeff, c, lat);
    n_total++; if (c !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a)
      $display("FAIL v1_ct got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", c); else n_pass++;
    n_total++; if (lat !== 10) $display("FAIL v1_latency got %0d want 10", lat); else n_pass++;
    @(posedge clk); #1;
    set_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    do_block(128, 128'h3243f6a8885a308d313198a2e0370734, c, lat);
    n_total++; if (c !== 128'h3925841d02dc09fbdc118597196a0b32)
      $display("FAIL v2_ct got %h want 3925841d02dc09fbdc118597196a0b32", c); else n_pass++;
    n_total++; if (r1_obs !== 128'ha49c7ff2689f352b6b5bea43026a5049)
      $display("FAIL v2_round1_state got %h want a49c7ff2689f352b6b5bea43026a5049", r1_obs); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_key_sizes();
    logic [127:0] c;
    int lat;
    or192 = 1'b1;
    or256 = 1'b1;
    set_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    do_block(192, 128'h00112233445566778899aabbccddeeff, c, lat);
    n_total++; if (c !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191)
      $display("FAIL v192_ct got %h want dda97ca4864cdfe06eaf70a0ec0d7191", c); else n_pass++;
    n_total++; if (lat !== 12) $display("FAIL v192_latency got %0d want 12", lat); else n_pass++;
    @(posedge clk); #1;
    set_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    do_block(256, 128'h00112233445566778899aabbccddeeff, c, lat);
    n_total++; if (c !== 128'h8ea2b7ca516745bfeafc49904b496089)
      $display("FAIL v256_ct got %h want 8ea2b7ca516745bfeafc49904b496089", c); else n_pass++;
    n_total++; if (lat !== 14) $display("FAIL v256_latency got %0d want 14", lat); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] c;
    logic [127:0] want;
    int lat;
    want = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    or128 = 1'b0;
    set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    do_block(128, 128'h00112233445566778899aabbccddeeff, c, lat);
    pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
    iv128 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_total++; if (ov128 !== 1'b1) $display("FAIL bp_out_valid cyc %0d got %b want 1", i, ov128); else n_pass++;
      n_total++; if (ct128 !== want) $display("FAIL bp_ct cyc %0d got %h want %h", i, ct128, want); else n_pass++;
      n_total++; if (bz128 !== 1'b1) $display("FAIL bp_busy cyc %0d got %b want 1", i, bz128); else n_pass++;
      n_total++; if (ir128 !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %b want 0", i, ir128); else n_pass++;
    end
    @(negedge clk);
    or128 = 1'b1;
    iv128 = 1'b0;
    @(posedge clk); #1;
    n_total++; if (ir128 !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", ir128); else n_pass++;
    n_total++; if (ov128 !== 1'b0) $display("FAIL bp_release_out_valid got %b want 0", ov128); else n_pass++;
    n_total++; if (bz128 !== 1'b0) $display("FAIL bp_release_busy got %b want 0", bz128); else n_pass++;
    n_total++; if (ct128 !== want) $display("FAIL bp_ct_held got %h want %h", ct128, want); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [127:0] c;
    int lat;
    int spurious;
    or128 = 1'b1;
    set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    pt    = 128'h00112233445566778899aabbccddeeff;
    iv128 = 1'b1;
    @(posedge clk); #1;
    iv128 = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_total++; if (ct128 !== 128'h0) $display("FAIL rstmid_ct got %h want 0", ct128); else n_pass++;
    n_total++; if (ov128 !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", ov128); else n_pass++;
    n_total++; if (bz128 !== 1'b0) $display("FAIL rstmid_busy got %b want 0", bz128); else n_pass++;
    n_total++; if (dut128.st !== 128'h0) $display("FAIL rstmid_state got %h want 0", dut128.st); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (ir128 !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", ir128); else n_pass++;
    spurious = 0;
    repeat (15) begin
      @(negedge clk);
      if (ov128 !== 1'b0) spurious++;
    end
    n_total++; if (spurious !== 0) $display("FAIL rstmid_dropped got %0d out_valid cycles want 0", spurious); else n_pass++;
    set_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    do_block(128, 128'h3243f6a8885a308d313198a2e0370734, c, lat);
    n_total++; if (c !== 128'h3925841d02dc09fbdc118597196a0b32)
      $display("FAIL rstmid_next_ct got %h want 3925841d02dc09fbdc118597196a0b32", c); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [255:0] key;
    logic [127:0] p;
    logic [127:0] want;
    time t_prev, t_now;
    int lat;
    or128 = 1'b1;
    key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    p   = {$urandom(), $urandom(), $urandom(), $urandom()};
    set_key(key, 4);
    model_enc(p, 10, want);
    pt     = p;
    iv128  = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 50; i++) begin
      lat = 0;
      while (!ov128 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      t_now = $time;
      n_total++; if (ct128 !== want) $display("FAIL b2b_ct blk %0d got %h want %h", i, ct128, want); else n_pass++;
      if (i > 0) begin
        n_total++; if (int'((t_now - t_prev) / 10) !== 12)
          $display("FAIL b2b_period blk %0d got %0d want 12", i, int'((t_now - t_prev) / 10)); else n_pass++;
      end
      t_prev = t_now;
      @(posedge clk); #1;
      if (i < 49) begin
        key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
        p   = {$urandom(), $urandom(), $urandom(), $urandom()};
        set_key(key, 4);
        model_enc(p, 10, want);
        pt = p;
      end else begin
        iv128 = 1'b0;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    init_sbox();
    test_reset();
    test_vec128();
    test_key_sizes();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
